// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: one full-subtractor cell plus a borrow flop.
// Operands are consumed LSB-first, one bit per clock. A request is accepted
// from IDLE, runs WIDTH shift cycles in SHIFT, then pulses done for one cycle
// in DONE before going back to IDLE.
//
// Handshake: start is sampled only in IDLE. a/b are captured on the accepting
// edge and ignored afterwards. busy is high exactly while in SHIFT. done is a
// one-cycle pulse in DONE. diff/borrow_out are valid from done onward and hold
// until the next completion. busy and done are never high together.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] r_sr;
    logic             br;
    logic [CW-1:0]    cnt;

    logic             d;
    logic             br_next;
    logic [WIDTH-1:0] r_next;

    // Full-subtractor cell on the current LSBs and the stored borrow.
    always_comb begin
        d       = a_sr[0] ^ b_sr[0] ^ br;
        br_next = (~a_sr[0] & b_sr[0]) | (~(a_sr[0] ^ b_sr[0]) & br);
        r_next  = {d, r_sr[WIDTH-1:1]};
    end

    // Control FSM and datapath registers; busy/done are registered decodes
    // of the next state, so they are glitch-free.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            a_sr       <= '0;
            b_sr       <= '0;
            r_sr       <= '0;
            br         <= 1'b0;
            cnt        <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            diff       <= '0;
            borrow_out <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sr  <= a;
                        b_sr  <= b;
                        r_sr  <= '0;
                        br    <= 1'b0;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    a_sr <= a_sr >> 1;
                    b_sr <= b_sr >> 1;
                    r_sr <= r_next;
                    br   <= br_next;
                    cnt  <= cnt + CW'(1);
                    // The WIDTH-th shift: publish the result, including this bit.
                    if (cnt == LAST_CNT) begin
                        diff       <= r_next;
                        borrow_out <= br_next;
                        busy       <= 1'b0;
                        done       <= 1'b1;
                        state      <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor: an 8-bit instance for directed/random/
// back-to-back/reset scenarios and a 4-bit instance for an exhaustive sweep.
// Expected results come from plain (a - b) arithmetic and a < b comparison.
module tb_serial_subtractor;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // ---------------- 8-bit instance ----------------
    logic       start8;
    logic [7:0] a8, b8;
    logic       busy8, done8;
    logic [7:0] diff8;
    logic       bor8;

    serial_subtractor #(.WIDTH(8)) dut8 (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start8),
        .a          (a8),
        .b          (b8),
        .busy       (busy8),
        .done       (done8),
        .diff       (diff8),
        .borrow_out (bor8)
    );

    // ---------------- 4-bit instance ----------------
    logic       start4;
    logic [3:0] a4, b4;
    logic       busy4, done4;
    logic [3:0] diff4;
    logic       bor4;

    serial_subtractor #(.WIDTH(4)) dut4 (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start4),
        .a          (a4),
        .b          (b4),
        .busy       (busy4),
        .done       (done4),
        .diff       (diff4),
        .borrow_out (bor4)
    );

    // ---------------- scoreboard ----------------
    int checks = 0;
    int errors = 0;
    logic [8:0] exp_q8[$];   // {borrow, diff}
    logic [4:0] exp_q4[$];
    logic [7:0] last_diff8 = '0;
    logic       last_bor8  = 1'b0;
    logic [3:0] last_diff4 = '0;
    logic       last_bor4  = 1'b0;

    // ---------------- driver tasks ----------------
    task automatic run_op8(input logic [7:0] av, input logic [7:0] bv);
        logic [8:0] exp;
        logic [7:0] dexp;
        int busy_cnt;
        int cyc;
        dexp = av - bv;
        exp_q8.push_back({(av < bv), dexp});
        a8 = av;
        b8 = bv;
        start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        a8 = 8'($urandom);
        b8 = 8'($urandom);
        busy_cnt = 0;
        cyc = 0;
        while (done8 !== 1'b1 && cyc < 40) begin
            if (busy8 === 1'b1) busy_cnt++;
            checks++;
            if (diff8 !== last_diff8 || bor8 !== last_bor8) begin
                errors++;
                $display("FAIL hold8 diff=%h borrow=%b expected diff=%h borrow=%b", diff8, bor8, last_diff8, last_bor8);
            end
            @(posedge clk); #1;
            cyc++;
        end
        exp = exp_q8.pop_front();
        checks++;
        if (done8 !== 1'b1) begin
            errors++;
            $display("FAIL timeout8 a=%h b=%h done=%b expected done=1", av, bv, done8);
        end else begin
            checks++;
            if ({bor8, diff8} !== exp) begin
                errors++;
                $display("FAIL result8 a=%h b=%h diff=%h borrow=%b expected diff=%h borrow=%b",
                         av, bv, diff8, bor8, exp[7:0], exp[8]);
            end
            checks++;
            if (busy_cnt != 8 || busy8 !== 1'b0) begin
                errors++;
                $display("FAIL busy8 busy_cycles=%0d busy_at_done=%b expected 8 and 0", busy_cnt, busy8);
            end
            last_diff8 = exp[7:0];
            last_bor8  = exp[8];
        end
        @(posedge clk); #1;
        checks++;
        if (done8 !== 1'b0 || busy8 !== 1'b0) begin
            errors++;
            $display("FAIL pulse8 done=%b busy=%b expected 0 0", done8, busy8);
        end
    endtask

    task automatic run_op4(input logic [3:0] av, input logic [3:0] bv);
        logic [4:0] exp;
        logic [3:0] dexp;
        int busy_cnt;
        int cyc;
        dexp = av - bv;
        exp_q4.push_back({(av < bv), dexp});
        a4 = av;
        b4 = bv;
        start4 = 1'b1;
        @(posedge clk); #1;
        start4 = 1'b0;
        a4 = 4'($urandom);
        b4 = 4'($urandom);
        busy_cnt = 0;
        cyc = 0;
        while (done4 !== 1'b1 && cyc < 30) begin
            if (busy4 === 1'b1) busy_cnt++;
            checks++;
            if (diff4 !== last_diff4 || bor4 !== last_bor4) begin
                errors++;
                $display("FAIL hold4 diff=%h borrow=%b expected diff=%h borrow=%b", diff4, bor4, last_diff4, last_bor4);
            end
            @(posedge clk); #1;
            cyc++;
        end
        exp = exp_q4.pop_front();
        checks++;
        if (done4 !== 1'b1) begin
            errors++;
            $display("FAIL timeout4 a=%h b=%h done=%b expected done=1", av, bv, done4);
        end else begin
            checks++;
            if ({bor4, diff4} !== exp) begin
                errors++;
                $display("FAIL result4 a=%h b=%h diff=%h borrow=%b expected diff=%h borrow=%b",
                         av, bv, diff4, bor4, exp[3:0], exp[4]);
            end
            checks++;
            if (busy_cnt != 4 || busy4 !== 1'b0) begin
                errors++;
                $display("FAIL busy4 busy_cycles=%0d busy_at_done=%b expected 4 and 0", busy_cnt, busy4);
            end
            last_diff4 = exp[3:0];
            last_bor4  = exp[4];
        end
        @(posedge clk); #1;
        checks++;
        if (done4 !== 1'b0 || busy4 !== 1'b0) begin
            errors++;
            $display("FAIL pulse4 done=%b busy=%b expected 0 0", done4, busy4);
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset;
        rst_n  = 1'b0;
        start8 = 1'b0; a8 = '0; b8 = '0;
        start4 = 1'b0; a4 = '0; b4 = '0;
        #12;
        checks++;
        if ({busy8, done8, diff8, bor8} !== 11'd0) begin
            errors++;
            $display("FAIL reset8 busy=%b done=%b diff=%h borrow=%b expected all 0", busy8, done8, diff8, bor8);
        end
        checks++;
        if ({busy4, done4, diff4, bor4} !== 7'd0) begin
            errors++;
            $display("FAIL reset4 busy=%b done=%b diff=%h borrow=%b expected all 0", busy4, done4, diff4, bor4);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        last_diff8 = '0; last_bor8 = 1'b0;
        last_diff4 = '0; last_bor4 = 1'b0;
    endtask

    task automatic test_directed;
        run_op8(8'd5, 8'd3);
        run_op8(8'd3, 8'd5);
        run_op8(8'h00, 8'h01);
        run_op8(8'h00, 8'h00);
        run_op8(8'hFF, 8'h00);
        run_op8(8'h80, 8'hFF);
    endtask

    task automatic test_back_to_back;
        int n_done;
        int cyc;
        int last_cyc;
        n_done   = 0;
        cyc      = 0;
        last_cyc = -1;
        a8 = 8'hA5;
        b8 = 8'h5A;
        start8 = 1'b1;
        while (n_done < 3 && cyc < 60) begin
            @(posedge clk); #1;
            cyc++;
            checks++;
            if (busy8 === 1'b1 && done8 === 1'b1) begin
                errors++;
                $display("FAIL overlap busy=%b done=%b expected not both 1", busy8, done8);
            end
            if (done8 === 1'b1) begin
                checks++;
                if (diff8 !== 8'h4B || bor8 !== 1'b0) begin
                    errors++;
                    $display("FAIL b2b_result diff=%h borrow=%b expected diff=4b borrow=0", diff8, bor8);
                end
                if (last_cyc >= 0) begin
                    checks++;
                    if (cyc - last_cyc != 10) begin
                        errors++;
                        $display("FAIL b2b_interval cycles=%0d expected 10", cyc - last_cyc);
                    end
                end
                last_cyc = cyc;
                n_done++;
                last_diff8 = 8'h4B;
                last_bor8  = 1'b0;
                a8 = 8'hA5;
                b8 = 8'h5A;
                if (n_done == 3) start8 = 1'b0;
            end else if (busy8 === 1'b1) begin
                checks++;
                if (diff8 !== last_diff8 || bor8 !== last_bor8) begin
                    errors++;
                    $display("FAIL b2b_hold diff=%h borrow=%b expected diff=%h borrow=%b", diff8, bor8, last_diff8, last_bor8);
                end
                a8 = 8'($urandom);
                b8 = 8'($urandom);
            end
        end
        start8 = 1'b0;
        checks++;
        if (n_done != 3) begin
            errors++;
            $display("FAIL b2b_count dones=%0d expected 3", n_done);
        end
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (busy8 !== 1'b0 || done8 !== 1'b0) begin
            errors++;
            $display("FAIL b2b_idle busy=%b done=%b expected 0 0", busy8, done8);
        end
    endtask

    task automatic test_mid_reset;
        a8 = 8'h10;
        b8 = 8'h20;
        start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy8, done8, diff8, bor8} !== 11'd0) begin
            errors++;
            $display("FAIL midreset busy=%b done=%b diff=%h borrow=%b expected all 0", busy8, done8, diff8, bor8);
        end
        last_diff8 = '0; last_bor8 = 1'b0;
        last_diff4 = '0; last_bor4 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            checks++;
            if (done8 !== 1'b0 || busy8 !== 1'b0 || diff8 !== 8'h00) begin
                errors++;
                $display("FAIL aborted done=%b busy=%b diff=%h expected 0 0 00", done8, busy8, diff8);
            end
        end
        run_op8(8'h10, 8'h20);
    endtask

    task automatic test_random8;
        for (int i = 0; i < 25; i++) begin
            run_op8(8'($urandom), 8'($urandom_range(255, 0)));
        end
    endtask

    task automatic test_sweep4;
        for (int ai = 0; ai < 16; ai++) begin
            for (int bi = 0; bi < 16; bi++) begin
                run_op4(4'(ai), 4'(bi));
            end
        end
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_mid_reset();
        test_random8();
        test_sweep4();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

Bit-serial N-bit subtractor built around a single full-subtractor cell and a borrow flip-flop. It processes operands LSB-first, one bit per clock. It is the subtract-direction companion to the combinational full adder and sits alongside it in the arithmetic block set. It trades WIDTH+2 cycles of latency for one-bit datapath area and uses a start/busy/done handshake.

## Interface
Parameters:
- WIDTH, 8, operand and result width in bits; legal range is WIDTH >= 2.

Ports:
- clk  input  1  the single clock; all state updates on its rising edge.
- rst_n  input  1  reset, asynchronous and active-low.
- start  input  1  request pulse; sampled only in IDLE.
- a  input  WIDTH  minuend; captured on the accepting edge.
- b  input  WIDTH  subtrahend; captured on the accepting edge.
- busy  output  1  high while an operation is in progress (SHIFT state).
- done  output  1  single-cycle pulse; result valid.
- diff  output  WIDTH  a - b modulo 2^WIDTH; registered.
- borrow_out  output  1  final borrow; 1 iff a < b unsigned.

## Operation
- FSM states: IDLE, SHIFT, DONE.
- IDLE with start=1 at a rising edge:
  - load a_sr<=a and b_sr<=b;
  - clear the borrow flop and clear cnt;
  - move to SHIFT.
- IDLE with start=0: remain in IDLE.
- SHIFT, once per edge:
  - d = a_sr[0] ^ b_sr[0] ^ br
  - br_next = (~a_sr[0] & b_sr[0]) | (~(a_sr[0] ^ b_sr[0]) & br)
  - a_sr and b_sr shift right by one.
  - d enters the MSB of the internal result shift register r_sr, which shifts right.
  - cnt increments.
- On the edge where cnt reaches WIDTH-1 (the WIDTH-th shift):
  - diff <= final r_sr contents, including the current d;
  - borrow_out <= br_next;
  - move to DONE.
- DONE: done=1 for exactly one cycle; the next edge returns to IDLE unconditionally.
- start is ignored in SHIFT and DONE. No queuing; a start held high across DONE is accepted in IDLE on the following edge.
- a and b are don't-care except on the accepting edge. Changing them mid-operation has no effect.
- diff and borrow_out hold their values from the last completed operation until the next completion. They do not change during busy.
- cnt width is $clog2(WIDTH). Arithmetic is unsigned two's-complement wrap: diff = (a - b) mod 2^WIDTH.

## Timing
- Reset (rst_n=0, at any time, including mid-SHIFT):
  - state=IDLE, busy=0, done=0;
  - diff=0, borrow_out=0, cnt=0, br=0;
  - shift registers cleared.
  - An in-flight operation is aborted and produces no done.
- After rst_n deasserts, start is first honoured at the first rising edge with rst_n=1.
- Accept edge E0: busy=1 from E0 through edge E0+WIDTH.
- The result registers update at edge E0+WIDTH. done=1 during the cycle between E0+WIDTH and E0+WIDTH+1.
- busy and done are never high together.
- Earliest next accept edge is E0+WIDTH+2. Sustained throughput is one result per WIDTH+2 cycles.
- busy and done are registered state decodes; they are glitch-free.

## Test plan
- Reset, then a=8'd5, b=8'd3, 1-cycle start → busy for 8 cycles; done one cycle later; diff=8'h02, borrow_out=0.
- a=8'd3, b=8'd5 → diff=8'hFE, borrow_out=1.
- a=8'h00, b=8'h01 → diff=8'hFF, borrow_out=1. Then a=8'h00, b=8'h00 → diff=8'h00, borrow_out=0, with the previous result held until the new done.
- start held high continuously with a=8'hA5, b=8'h5A → done every 10 cycles; diff=8'h4B, borrow_out=0. Operand changes during busy do not alter the result.
- Drop rst_n at the 4th SHIFT cycle of a=8'h10, b=8'h20 → outputs immediately 0 and no done. After release, a=8'h10, b=8'h20 → diff=8'hF0, borrow_out=1.
- Random and exhaustive WIDTH=4 sweep (all 256 pairs) → diff, borrow_out match the (a-b) reference model, with exactly one done per accepted start.
